// File: rtl/wash_timer_sequencer.sv
`timescale 1ns/1ps
// wash_timer_sequencer
// Sequences a washer run: IDLE -> ARMED -> WASH -> DRAIN -> SPIN -> IDLE.
// A shared prescaler divides Clock into timing ticks. WASH and SPIN each
// count their length in ticks. Pause freezes the timing but never blocks
// state transitions. When Door_Lock falls during a run, the run is cancelled,
// and that cancellation takes priority over any expiry in the same cycle.
// Every output is driven straight from a flop.
module wash_timer_sequencer #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned QUICK_TICKS  = 8,
  parameter int unsigned NORMAL_TICKS = 20,
  parameter int unsigned HEAVY_TICKS  = 40,
  parameter int unsigned SPIN_TICKS   = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] Program,
  input  logic       Door_Lock,
  input  logic       Motor_on,
  input  logic       Drained,
  input  logic       Pause,
  output logic       Cycle_Timeout,
  output logic       Spin_Timeout,
  output logic       Abort,
  output logic       Busy,
  output logic [2:0] Phase,
  output logic [7:0] Remaining
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ARMED = 3'b001,
    WASH  = 3'b010,
    DRAIN = 3'b011,
    SPIN  = 3'b100
  } state_e;

  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [7:0]  QUICK_LEN  = 8'(QUICK_TICKS);
  localparam logic [7:0]  NORMAL_LEN = 8'(NORMAL_TICKS);
  localparam logic [7:0]  HEAVY_LEN  = 8'(HEAVY_TICKS);
  localparam logic [7:0]  SPIN_LEN   = 8'(SPIN_TICKS);

  // Wash length for a latched program code; code 11 is run as normal.
  function automatic logic [7:0] wash_len(input logic [1:0] prog);
    logic [7:0] len;
    case (prog)
      2'b00:   len = QUICK_LEN;
      2'b01:   len = NORMAL_LEN;
      2'b10:   len = HEAVY_LEN;
      2'b11:   len = NORMAL_LEN;
      default: len = NORMAL_LEN;
    endcase
    return len;
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  prog_q, prog_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  rem_q, rem_d;
  logic        cyc_to_q, cyc_to_d;
  logic        spin_to_q, spin_to_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        timed_s;
  logic        run_s;
  logic        tick_s;

  // The prescaler runs only in a timed phase while not paused.
  assign timed_s = (state_q == WASH) || (state_q == SPIN);
  assign run_s   = timed_s && !Pause;
  assign tick_s  = run_s && (presc_q == TICK_LAST);

  // State register, with asynchronous clear of the run and all outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      prog_q    <= 2'b00;
      presc_q   <= 16'd0;
      rem_q     <= 8'd0;
      cyc_to_q  <= 1'b0;
      spin_to_q <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      presc_q   <= presc_d;
      rem_q     <= rem_d;
      cyc_to_q  <= cyc_to_d;
      spin_to_q <= spin_to_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state, prescaler, tick countdown and pulse generation.
  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    presc_d   = presc_q;
    rem_d     = rem_q;
    cyc_to_d  = 1'b0;
    spin_to_d = 1'b0;
    abort_d   = 1'b0;

    if (tick_s) begin
      presc_d = 16'd0;
    end else if (run_s) begin
      presc_d = presc_q + 16'd1;
    end else begin
      presc_d = presc_q;
    end

    case (state_q)
      IDLE: begin
        rem_d   = 8'd0;
        presc_d = 16'd0;
        if (Door_Lock) begin
          state_d = ARMED;
          prog_d  = Program;
        end else begin
          state_d = IDLE;
        end
      end

      ARMED: begin
        if (!Door_Lock) begin
          state_d = IDLE;
          rem_d   = 8'd0;
          presc_d = 16'd0;
          abort_d = 1'b1;
        end else if (Motor_on) begin
          state_d = WASH;
          rem_d   = wash_len(prog_q);
          presc_d = 16'd0;
        end else begin
          state_d = ARMED;
        end
      end

      WASH: begin
        if (!Door_Lock) begin
          state_d = IDLE;
          rem_d   = 8'd0;
          presc_d = 16'd0;
          abort_d = 1'b1;
        end else if (tick_s && Motor_on) begin
          // Ticks with the motor stopped are dropped, not deferred.
          if (rem_q <= 8'd1) begin
            state_d  = DRAIN;
            rem_d    = 8'd0;
            cyc_to_d = 1'b1;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end else begin
          state_d = WASH;
        end
      end

      DRAIN: begin
        if (!Door_Lock) begin
          state_d = IDLE;
          rem_d   = 8'd0;
          presc_d = 16'd0;
          abort_d = 1'b1;
        end else if (Drained) begin
          state_d = SPIN;
          rem_d   = SPIN_LEN;
          presc_d = 16'd0;
        end else begin
          state_d = DRAIN;
        end
      end

      SPIN: begin
        if (!Door_Lock) begin
          state_d = IDLE;
          rem_d   = 8'd0;
          presc_d = 16'd0;
          abort_d = 1'b1;
        end else if (tick_s) begin
          if (rem_q <= 8'd1) begin
            state_d   = IDLE;
            rem_d     = 8'd0;
            presc_d   = 16'd0;
            spin_to_d = 1'b1;
          end else begin
            rem_d = rem_q - 8'd1;
          end
        end else begin
          state_d = SPIN;
        end
      end

      default: begin
        state_d = IDLE;
        rem_d   = 8'd0;
        presc_d = 16'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign Cycle_Timeout = cyc_to_q;
  assign Spin_Timeout  = spin_to_q;
  assign Abort         = abort_q;
  assign Busy          = busy_q;
  assign Phase         = state_q;
  assign Remaining     = rem_q;

endmodule

// File: tb/tb_wash_timer_sequencer.sv
`timescale 1ns/1ps
// Directed bench for wash_timer_sequencer, with a small tick configuration
// (4 cycles per tick, quick=3, normal=5, heavy=7, spin=2 ticks).
module tb_wash_timer_sequencer;

  logic       Clock;
  logic       Reset;
  logic [1:0] Program;
  logic       Door_Lock;
  logic       Motor_on;
  logic       Drained;
  logic       Pause;
  logic       Cycle_Timeout;
  logic       Spin_Timeout;
  logic       Abort;
  logic       Busy;
  logic [2:0] Phase;
  logic [7:0] Remaining;

  int checks = 0;
  int errors = 0;
  logic seen_pulse;

  wash_timer_sequencer #(
    .TICK_DIV    (4),
    .QUICK_TICKS (3),
    .NORMAL_TICKS(5),
    .HEAVY_TICKS (7),
    .SPIN_TICKS  (2)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Program      (Program),
    .Door_Lock    (Door_Lock),
    .Motor_on     (Motor_on),
    .Drained      (Drained),
    .Pause        (Pause),
    .Cycle_Timeout(Cycle_Timeout),
    .Spin_Timeout (Spin_Timeout),
    .Abort        (Abort),
    .Busy         (Busy),
    .Phase        (Phase),
    .Remaining    (Remaining)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1ns past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ct"},    {7'd0, Cycle_Timeout}, 8'd0);
    chk({tag, "_st"},    {7'd0, Spin_Timeout},  8'd0);
    chk({tag, "_ab"},    {7'd0, Abort},         8'd0);
    chk({tag, "_busy"},  {7'd0, Busy},          8'd0);
    chk({tag, "_phase"}, {5'd0, Phase},         8'd0);
    chk({tag, "_rem"},   Remaining,             8'd0);
  endtask

  initial begin
    Reset = 1'b1; Program = 2'b00; Door_Lock = 1'b0; Motor_on = 1'b0;
    Drained = 1'b0; Pause = 1'b0;

    // Asynchronous reset before any clock edge
    #2 Reset = 1'b0;
    #1 chk_all_zero("reset");
    cyc(2);
    Reset = 1'b1;
    cyc(1);
    chk("idle_wait_phase", {5'd0, Phase}, 8'd0);

    // Quick program: full wash / drain / spin run
    Program = 2'b00; Door_Lock = 1'b1;
    cyc(1);
    chk("armed_phase", {5'd0, Phase}, 8'd1);
    chk("armed_busy", {7'd0, Busy}, 8'd1);
    Program = 2'b10;            // must be ignored: program already latched
    Motor_on = 1'b1;
    cyc(1);
    chk("wash_phase", {5'd0, Phase}, 8'd2);
    chk("wash_load_quick", Remaining, 8'd3);
    cyc(4);
    chk("wash_rem_after_1tick", Remaining, 8'd2);
    cyc(7);
    chk("wash_ct_not_yet", {7'd0, Cycle_Timeout}, 8'd0);
    chk("wash_rem_1", Remaining, 8'd1);
    cyc(1);
    chk("ct_at_12", {7'd0, Cycle_Timeout}, 8'd1);
    chk("drain_phase", {5'd0, Phase}, 8'd3);
    chk("drain_rem", Remaining, 8'd0);
    cyc(1);
    chk("ct_one_cycle", {7'd0, Cycle_Timeout}, 8'd0);
    chk("drain_hold", {5'd0, Phase}, 8'd3);
    Drained = 1'b1;
    cyc(1);
    chk("spin_phase", {5'd0, Phase}, 8'd4);
    chk("spin_load", Remaining, 8'd2);
    Drained = 1'b0;
    cyc(7);
    chk("spin_st_not_yet", {7'd0, Spin_Timeout}, 8'd0);
    chk("spin_rem_1", Remaining, 8'd1);
    cyc(1);
    chk("st_at_8", {7'd0, Spin_Timeout}, 8'd1);
    chk("st_phase_idle", {5'd0, Phase}, 8'd0);
    chk("st_busy", {7'd0, Busy}, 8'd0);
    Door_Lock = 1'b0; Motor_on = 1'b0;
    cyc(1);
    chk("st_one_cycle", {7'd0, Spin_Timeout}, 8'd0);

    // Pause for 5 cycles mid-wash delays expiry by 5 cycles
    Program = 2'b00; Door_Lock = 1'b1; Motor_on = 1'b1;
    cyc(2);
    chk("p_wash_phase", {5'd0, Phase}, 8'd2);
    cyc(5);
    Pause = 1'b1;
    cyc(5);
    chk("p_rem_held", Remaining, 8'd2);
    Pause = 1'b0;
    cyc(6);
    chk("p_ct_not_yet", {7'd0, Cycle_Timeout}, 8'd0);
    cyc(1);
    chk("p_ct_at_17", {7'd0, Cycle_Timeout}, 8'd1);

    // Drain -> spin still happens while paused; timing stays frozen
    Pause = 1'b1; Drained = 1'b1;
    cyc(1);
    chk("p_spin_phase", {5'd0, Phase}, 8'd4);
    cyc(3);
    chk("p_spin_rem_held", Remaining, 8'd2);
    Pause = 1'b0; Drained = 1'b0;

    // Door opened on the spin expiry tick: abort wins
    cyc(7);
    chk("ab_spin_rem_1", Remaining, 8'd1);
    Door_Lock = 1'b0;
    cyc(1);
    chk("ab_spin_abort", {7'd0, Abort}, 8'd1);
    chk("ab_spin_no_st", {7'd0, Spin_Timeout}, 8'd0);
    chk("ab_spin_phase", {5'd0, Phase}, 8'd0);
    chk("ab_spin_rem", Remaining, 8'd0);
    cyc(1);
    chk("ab_one_cycle", {7'd0, Abort}, 8'd0);
    chk("ab_no_late_st", {7'd0, Spin_Timeout}, 8'd0);

    // Reset pulsed mid-wash
    Program = 2'b00; Door_Lock = 1'b1; Motor_on = 1'b1;
    cyc(2);
    chk("r_wash_phase", {5'd0, Phase}, 8'd2);
    cyc(3);
    #2 Reset = 1'b0;
    #1 chk_all_zero("midrun_reset");
    Door_Lock = 1'b0;
    cyc(1);
    Reset = 1'b1;
    seen_pulse = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen_pulse = seen_pulse | Cycle_Timeout | Spin_Timeout;
    end
    chk("r_no_timeout", {7'd0, seen_pulse}, 8'd0);
    chk("r_idle", {5'd0, Phase}, 8'd0);

    // Program 11 runs as normal; later program change ignored
    Program = 2'b11; Door_Lock = 1'b1;
    cyc(2);
    chk("n_wash_phase", {5'd0, Phase}, 8'd2);
    chk("n_load_normal", Remaining, 8'd5);
    Program = 2'b10;
    cyc(19);
    chk("n_rem_1", Remaining, 8'd1);
    chk("n_ct_not_yet", {7'd0, Cycle_Timeout}, 8'd0);
    cyc(1);
    chk("n_ct_at_20", {7'd0, Cycle_Timeout}, 8'd1);

    // Door opened in drain
    Door_Lock = 1'b0;
    cyc(1);
    chk("d_abort", {7'd0, Abort}, 8'd1);
    chk("d_phase", {5'd0, Phase}, 8'd0);

    // Heavy program; ticks with motor stopped are discarded, then abort in wash
    Program = 2'b10; Door_Lock = 1'b1;
    cyc(2);
    chk("h_load_heavy", Remaining, 8'd7);
    Motor_on = 1'b0;
    cyc(8);
    chk("h_motor_off_hold", Remaining, 8'd7);
    chk("h_phase", {5'd0, Phase}, 8'd2);
    Door_Lock = 1'b0;
    cyc(1);
    chk("h_abort", {7'd0, Abort}, 8'd1);
    chk("h_abort_rem", Remaining, 8'd0);

    // Abort from armed
    Door_Lock = 1'b1;
    cyc(1);
    chk("a_armed", {5'd0, Phase}, 8'd1);
    Door_Lock = 1'b0;
    cyc(1);
    chk("a_abort", {7'd0, Abort}, 8'd1);
    chk("a_idle", {5'd0, Phase}, 8'd0);
    cyc(1);
    chk("a_abort_gone", {7'd0, Abort}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_timer_sequencer.md
WASH_TIMER_SEQUENCER -- requirements
Module: wash_timer_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000: Clock cycles per timing tick; legal range 2..65535.
REQ-002 Parameter QUICK_TICKS, default 8: wash duration in ticks for Program 00; legal range 1..255.
REQ-003 Parameter NORMAL_TICKS, default 20: wash duration in ticks for Program 01 and 11; legal range 1..255.
REQ-004 Parameter HEAVY_TICKS, default 40: wash duration in ticks for Program 10; legal range 1..255.
REQ-005 Parameter SPIN_TICKS, default 10: spin duration in ticks; legal range 1..255.
REQ-006 Clock  input  1  system clock; all state changes on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-low reset.
REQ-008 Program  input  2  wash program select: 00 quick, 01 normal, 10 heavy, 11 treated as normal.
REQ-009 Door_Lock  input  1  door-lock level from the washer controller.
REQ-010 Motor_on  input  1  motor-on level from the washer controller.
REQ-011 Drained  input  1  drum-empty sensor level.
REQ-012 Pause  input  1  level; freezes all timing while high.
REQ-013 Cycle_Timeout  output  1  one-cycle pulse ending the wash phase.
REQ-014 Spin_Timeout  output  1  one-cycle pulse ending the spin phase.
REQ-015 Abort  output  1  one-cycle pulse when a run is cancelled by Door_Lock falling.
REQ-016 Busy  output  1  high in every state except IDLE.
REQ-017 Phase  output  3  encoded state: IDLE 000, ARMED 001, WASH 010, DRAIN 011, SPIN 100.
REQ-018 Remaining  output  8  ticks left in the current timed phase; 0 outside WASH and SPIN.

Function
REQ-019 The block SHALL implement the states IDLE, ARMED, WASH, DRAIN and SPIN, with all outputs registered.
REQ-020 IDLE->ARMED SHALL occur when Door_Lock is sampled 1; Program is latched on this edge, and later Program changes are ignored until the next IDLE.
REQ-021 ARMED->WASH SHALL occur when Motor_on is sampled 1; on this edge Remaining loads the latched program duration and the prescaler clears to 0.
REQ-022 The prescaler SHALL count 0..TICK_DIV-1 only in WASH and SPIN with Pause=0; a tick is the cycle in which the prescaler equals TICK_DIV-1, after which it wraps to 0.
REQ-023 In WASH, each tick SHALL decrement Remaining when Motor_on=1; ticks with Motor_on=0 SHALL be discarded.
REQ-024 At the WASH tick edge where Remaining=1: Remaining<=0, Cycle_Timeout<=1 for exactly one cycle, and state<=DRAIN.
REQ-025 DRAIN->SPIN SHALL occur when Drained is sampled 1; on this edge Remaining<=SPIN_TICKS and the prescaler clears.
REQ-026 In SPIN, each tick SHALL decrement Remaining; at the tick edge where Remaining=1: Remaining<=0, Spin_Timeout<=1 for one cycle, and state<=IDLE.
REQ-027 With Pause=1, the prescaler and Remaining SHALL hold, no tick is generated, and state transitions (including DRAIN->SPIN) SHALL still occur.
REQ-028 Door_Lock sampled 0 in ARMED, WASH, DRAIN or SPIN SHALL cause state<=IDLE, Remaining<=0 and Abort<=1 for one cycle.
REQ-029 If an abort and an expiry coincide, the abort SHALL win: no Cycle_Timeout or Spin_Timeout is issued.
REQ-030 Cycle_Timeout, Spin_Timeout and Abort SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-031 Busy and Phase SHALL reflect the registered state, with no combinational path from inputs to outputs.

Reset
REQ-032 Reset low SHALL immediately force state IDLE, prescaler 0, Remaining 0, and Cycle_Timeout, Spin_Timeout, Abort and Busy all 0, and Phase 000, regardless of Clock.
REQ-033 Reset asserted mid-run SHALL discard the latched program, and no timeout pulse SHALL follow its release.
REQ-034 After Reset rises, the block SHALL wait in IDLE for Door_Lock.

Verification (TICK_DIV=4, QUICK_TICKS=3, SPIN_TICKS=2)
REQ-035 Program=00, then Door_Lock=1, then Motor_on=1 held -> Cycle_Timeout pulses exactly 12 cycles after WASH entry, and Phase becomes 011.
REQ-036 In DRAIN, Drained=1 -> SPIN with Remaining=2; Spin_Timeout pulses 8 cycles later, then Phase=000 and Busy=0.
REQ-037 Pause=1 for 5 cycles mid-WASH -> the Cycle_Timeout pulse is delayed by exactly 5 cycles versus REQ-035.
REQ-038 Door_Lock dropped in SPIN with Remaining=1 on the tick cycle -> one Abort pulse, no Spin_Timeout, and Phase=000.
REQ-039 Reset pulsed low mid-WASH -> all outputs are 0 asynchronously, and no Cycle_Timeout occurs afterwards with Door_Lock=0.
REQ-040 Program=11 -> Remaining loads NORMAL_TICKS; Program changed to 10 during WASH -> duration is unchanged.
